// File: rtl/noc_input_port_xy.sv
// NoC router input port: DEPTH-entry packet FIFO with XY route
// computed at enqueue and a one-hot output request for the head.
module noc_input_port_xy #(
  parameter int PKT_W   = 13,
  parameter int COORD_W = 2,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [COORD_W-1:0]       my_x,
  input  logic [COORD_W-1:0]       my_y,
  input  logic                     valid_in,
  input  logic [PKT_W-1:0]         packet_in,
  output logic                     ready_out,
  output logic                     out_valid,
  output logic [PKT_W-1:0]         out_packet,
  output logic [4:0]               out_req,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         pkt_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  localparam logic [2:0] P_LOCAL = 3'd0;
  localparam logic [2:0] P_EAST  = 3'd1;
  localparam logic [2:0] P_WEST  = 3'd2;
  localparam logic [2:0] P_NORTH = 3'd3;
  localparam logic [2:0] P_SOUTH = 3'd4;

  logic [PKT_W-1:0]   r_mem  [DEPTH];
  logic [2:0]         r_port [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [OW-1:0]      r_occ;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_live;

  logic [COORD_W-1:0] w_dx;
  logic [COORD_W-1:0] w_dy;
  logic               w_x_gt;
  logic               w_x_lt;
  logic               w_x_eq;
  logic               w_y_gt;
  logic               w_y_lt;
  logic [2:0]         w_route;
  logic               w_push;
  logic               w_pop;

  assign w_dx = packet_in[PKT_W-1 -: COORD_W];
  assign w_dy = packet_in[PKT_W-1-COORD_W -: COORD_W];

  assign w_x_gt = w_dx > my_x;
  assign w_x_lt = w_dx < my_x;
  assign w_x_eq = w_dx == my_x;
  assign w_y_gt = w_dy > my_y;
  assign w_y_lt = w_dy < my_y;

  // X is resolved fully before Y is considered.
  always_comb begin
    w_route = P_LOCAL;
    unique case (1'b1)
      w_x_gt:           w_route = P_EAST;
      w_x_lt:           w_route = P_WEST;
      w_x_eq && w_y_gt: w_route = P_NORTH;
      w_x_eq && w_y_lt: w_route = P_SOUTH;
      default:          w_route = P_LOCAL;
    endcase
  end

  // r_live keeps ready low until the first edge after reset release.
  assign ready_out = r_live && (r_occ != OW'(DEPTH));
  assign out_valid = (r_occ != '0);
  assign w_push    = valid_in && ready_out;
  assign w_pop     = out_valid && out_ready;

  assign out_packet = out_valid ? r_mem[r_rd_ptr] : '0;
  assign out_req    = out_valid ? (5'b00001 << r_port[r_rd_ptr]) : '0;

  assign occupancy = r_occ;
  assign pkt_count = r_cnt;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr]  <= packet_in;
      r_port[r_wr_ptr] <= w_route;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_cnt    <= '0;
      r_live   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
      if (w_push && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_input_port_xy.sv
// Bench for noc_input_port_xy: route table, fill/stream/wrap,
// steady occupancy, counter saturation and mid-operation reset.
module tb_noc_input_port_xy;

  logic        clk;
  logic        reset;
  logic [1:0]  my_x;
  logic [1:0]  my_y;
  logic        valid_in;
  logic [12:0] packet_in;
  logic        out_ready;

  logic        ready_out;
  logic        out_valid;
  logic [12:0] out_packet;
  logic [4:0]  out_req;
  logic [2:0]  occupancy;
  logic [15:0] pkt_count;

  logic        ready_out2;
  logic        out_valid2;
  logic [12:0] out_packet2;
  logic [4:0]  out_req2;
  logic [2:0]  occupancy2;
  logic [2:0]  pkt_count2;

  noc_input_port_xy dut (
    .clk(clk), .reset(reset), .my_x(my_x), .my_y(my_y),
    .valid_in(valid_in), .packet_in(packet_in),
    .ready_out(ready_out), .out_valid(out_valid),
    .out_packet(out_packet), .out_req(out_req),
    .out_ready(out_ready), .occupancy(occupancy),
    .pkt_count(pkt_count)
  );

  noc_input_port_xy #(.CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .my_x(my_x), .my_y(my_y),
    .valid_in(valid_in), .packet_in(packet_in),
    .ready_out(ready_out2), .out_valid(out_valid2),
    .out_packet(out_packet2), .out_req(out_req2),
    .out_ready(out_ready), .occupancy(occupancy2),
    .pkt_count(pkt_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] dx;
    logic [1:0] dy;
    logic [4:0] req;
  } vec_t;

  typedef struct {
    logic [12:0] pkt;
    logic [4:0]  req;
  } sb_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cnt   = 0;
  bit   mon_en = 0;
  sb_t  q[$];
  vec_t tbl[5];

  bit          prev_hold = 0;
  logic [12:0] prev_pkt;
  logic [4:0]  prev_req;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] xy_req(input logic [12:0] p,
                                        input logic [1:0] mx,
                                        input logic [1:0] my);
    logic [1:0] dx;
    logic [1:0] dy;
    dx = p[12:11];
    dy = p[10:9];
    if (dx > mx) return 5'b00010;
    if (dx < mx) return 5'b00100;
    if (dy > my) return 5'b01000;
    if (dy < my) return 5'b10000;
    return 5'b00001;
  endfunction

  // Scoreboard monitor: state is stable mid-cycle, the edge follows.
  always @(negedge clk) begin
    if (reset && mon_en) begin
      chk("occ", 32'(occupancy), 32'(q.size()));
      chk("ready", 32'(ready_out), 32'(q.size() != 4));
      chk("valid", 32'(out_valid), 32'(q.size() != 0));
      chk("cnt", 32'(pkt_count), 32'(cnt));
      chk("cnt_sat", 32'(pkt_count2), 32'((cnt > 7) ? 7 : cnt));
      if (prev_hold && out_valid) begin
        chk("hold_pkt", 32'(out_packet), 32'(prev_pkt));
        chk("hold_req", 32'(out_req), 32'(prev_req));
      end
      if (out_valid && q.size() != 0) begin
        chk("sb_pkt", 32'(out_packet), 32'(q[0].pkt));
        chk("sb_req", 32'(out_req), 32'(q[0].req));
        if (out_ready) void'(q.pop_front());
      end else begin
        chk("idle_req", 32'(out_req), 32'd0);
      end
      prev_hold = out_valid && !out_ready;
      prev_pkt  = out_packet;
      prev_req  = out_req;
      if (valid_in && ready_out) begin
        q.push_back('{packet_in, xy_req(packet_in, my_x, my_y)});
        cnt++;
      end
    end else begin
      prev_hold = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_req", 32'(out_req), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_ready", 32'(ready_out), 32'd0);
    chk("rst_pkt", 32'(out_packet), 32'd0);
    chk("rst_cnt", 32'(pkt_count), 32'd0);
    q.delete();
    cnt = 0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    step();
    chk("rel_ready", 32'(ready_out), 32'd1);
    chk("rel_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic drain();
    valid_in  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && out_valid; i++) step();
    chk("drain_done", 32'(out_valid), 32'd0);
    chk("drain_sb", 32'(q.size()), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    int acc;
    logic [12:0] p;

    tbl[0] = '{2'd1, 2'd1, 5'b00001};
    tbl[1] = '{2'd2, 2'd0, 5'b00010};
    tbl[2] = '{2'd0, 2'd3, 5'b00100};
    tbl[3] = '{2'd1, 2'd3, 5'b01000};
    tbl[4] = '{2'd1, 2'd0, 5'b10000};

    reset     = 1'b0;
    my_x      = 2'd1;
    my_y      = 2'd1;
    valid_in  = 1'b0;
    packet_in = '0;
    out_ready = 1'b0;
    step();
    do_reset();
    mon_en = 1;

    // Route table, one packet at a time.
    for (int i = 0; i < 5; i++) begin
      p = {tbl[i].dx, tbl[i].dy, 9'(i * 37 + 5)};
      valid_in  = 1'b1;
      packet_in = p;
      step();
      valid_in = 1'b0;
      chk("tbl_valid", 32'(out_valid), 32'd1);
      chk("tbl_req", 32'(out_req), 32'(tbl[i].req));
      chk("tbl_pkt", 32'(out_packet), 32'(p));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end

    // Fill with out_ready low: exactly DEPTH accepted.
    do_reset();
    acc = 0;
    valid_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      packet_in = 13'($urandom);
      @(negedge clk);
      if (ready_out) acc++;
      step();
    end
    chk("fill_acc", 32'(acc), 32'd4);
    chk("fill_occ", 32'(occupancy), 32'd4);
    chk("fill_cnt", 32'(pkt_count), 32'd4);
    chk("fill_ready", 32'(ready_out), 32'd0);

    // Full then stream: no same-cycle refill, ready back next cycle.
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_ready", 32'(ready_out), 32'd0);
    step();
    chk("after_pop_ready", 32'(ready_out), 32'd1);
    chk("after_pop_occ", 32'(occupancy), 32'd3);
    for (int i = 0; i < 12; i++) begin
      packet_in = 13'($urandom);
      step();
    end
    drain();
    chk("sat_hold", 32'(pkt_count2), 32'd7);

    // Steady push+pop at occupancy 2 with a different router position.
    my_x = 2'd2;
    my_y = 2'd2;
    valid_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      packet_in = 13'($urandom);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      packet_in = 13'($urandom);
      step();
      chk("steady_occ", 32'(occupancy), 32'd2);
    end
    drain();

    // Reset with three packets buffered.
    my_x = 2'd1;
    my_y = 2'd1;
    valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      packet_in = 13'($urandom);
      step();
    end
    valid_in = 1'b0;
    chk("pre_rst_occ", 32'(occupancy), 32'd3);
    #2;
    do_reset();
    repeat (3) step();
    chk("no_stale_valid", 32'(out_valid), 32'd0);
    chk("no_stale_occ", 32'(occupancy), 32'd0);
    valid_in  = 1'b1;
    packet_in = {2'd3, 2'd1, 9'h0a5};
    step();
    valid_in = 1'b0;
    chk("post_rst_req", 32'(out_req), 32'b00010);
    drain();

    step();
    mon_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/noc_input_port_xy.md
Name: noc_input_port_xy

Overview:
Parametrised successor to the NoC router input port. It buffers incoming packets in a DEPTH-entry FIFO and computes a dimension-ordered (XY) route at enqueue time. The route is stored with each packet, and the head packet is presented with a one-hot output-port request. It sits between an upstream packet source or link and the router crossbar/arbiter, using valid/ready handshakes on both sides.

Parameters:
PKT_W, 13, packet width in bits; the destination field occupies the top 2*COORD_W bits.
COORD_W, 2, width of each X/Y coordinate.
DEPTH, 4, FIFO entries; power of two, minimum 2.
CNT_W, 16, width of the accepted-packet counter.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
my_x  input  COORD_W  this router's X coordinate; quasi-static
my_y  input  COORD_W  this router's Y coordinate; quasi-static
valid_in  input  1  upstream packet valid
packet_in  input  PKT_W  upstream packet
ready_out  output  1  port can accept a packet this cycle
out_valid  output  1  head packet available
out_packet  output  PKT_W  head packet
out_req  output  5  one-hot output request: bit0 LOCAL, bit1 EAST, bit2 WEST, bit3 NORTH, bit4 SOUTH
out_ready  input  1  crossbar accepts the head packet
occupancy  output  $clog2(DEPTH)+1  current FIFO fill level
pkt_count  output  CNT_W  packets accepted since reset; saturating

Behaviour:
- Destination fields: dest_x = packet_in[PKT_W-1 -: COORD_W]; dest_y = packet_in[PKT_W-1-COORD_W -: COORD_W]. Coordinates are unsigned.
- XY route, computed combinationally from packet_in and stored in the FIFO as a 3-bit port index alongside the packet:
  - dest_x > my_x -> EAST
  - dest_x < my_x -> WEST
  - else dest_y > my_y -> NORTH
  - dest_y < my_y -> SOUTH
  - else LOCAL
- Push: push = valid_in & ready_out. ready_out = (occupancy != DEPTH). ready_out is a function of registered state only; it never depends combinationally on valid_in or out_ready.
- Pop: pop = out_valid & out_ready. out_valid = (occupancy != 0).
- out_packet and out_req are driven from the head entry. out_req is one-hot when out_valid = 1 and all-zero when out_valid = 0.
- Latency: a packet pushed into an empty FIFO at edge N is presented (out_valid = 1) in the cycle after edge N. There is no combinational bypass from packet_in to out_packet.
- Simultaneous push and pop when not full and not empty: both happen, occupancy is unchanged, and pointers advance.
- Full FIFO with out_ready = 1: the pop occurs, but ready_out is still 0 in that cycle, so no same-cycle refill. ready_out rises the next cycle.
- Empty FIFO with out_ready = 1: no pop; pointers are unchanged.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. occupancy is tracked in a separate counter.
- out_packet and out_req must stay stable while out_valid = 1 and out_ready = 0.
- pkt_count increments on each push and saturates at 2^CNT_W - 1 (no wrap).
- Reset (reset = 0, asynchronous assert, synchronous-safe deassert), mid-operation included:
  - pointers = 0, occupancy = 0, pkt_count = 0
  - out_valid = 0, out_req = 0
  - ready_out = 0 while reset is asserted, 1 from the first cycle after deassertion
  - out_packet = 0
  - buffered packets are discarded

Test Plan:
- my_x=1, my_y=1; push packets with (dest_x,dest_y) = (1,1), (2,0), (0,3), (1,3), (1,0) into 13-bit packets, out_ready=1 -> out_req = 00001, 00010, 00100, 01000, 10000 in order. X takes priority over Y for (2,0) and (0,3).
- DEPTH=4, out_ready=0, valid_in held high for 6 cycles -> exactly 4 accepted; ready_out=0 from the 4th acceptance; occupancy=4; pkt_count=4.
- Full FIFO, then out_ready=1 with valid_in=1 -> one pop per cycle; ready_out returns 1 the cycle after the first pop; FIFO order preserved across pointer wrap (≥10 packets streamed).
- Continuous push and pop at occupancy 2 for 20 cycles -> occupancy stays 2; output sequence equals input sequence.
- CNT_W=3, push 9 packets -> pkt_count reads 7 and holds.
- Assert reset while occupancy=3 -> out_valid and out_req drop to 0 and occupancy = 0 immediately, without waiting for a clock edge; after deassertion no stale packet appears.
